// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-word field layout and the NOP encoding.
// Stage wrappers pack/unpack control through these so all boundaries agree.
package pipe_pkg;

    localparam int CTRL_W = 9;

    localparam int REGWRITE_BIT   = 0;
    localparam int MEMTOREG_LSB   = 1;
    localparam int MEMTOREG_W     = 2;
    localparam int MEMWRITE_BIT   = 3;
    localparam int ALUCONTROL_LSB = 4;
    localparam int ALUCONTROL_W   = 3;
    localparam int ALUSRC_BIT     = 7;
    localparam int REGDST_BIT     = 8;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    // Field order mirrors the bit offsets above (MSB first).
    typedef struct packed {
        logic                    regdst;
        logic                    alusrc;
        logic [ALUCONTROL_W-1:0] alucontrol;
        logic                    memwrite;
        logic [MEMTOREG_W-1:0]   memtoreg;
        logic                    regwrite;
    } ctrl_t;

    function automatic logic [CTRL_W-1:0] pack_ctrl(input ctrl_t c);
        return c;
    endfunction

    function automatic ctrl_t unpack_ctrl(input logic [CTRL_W-1:0] w);
        return ctrl_t'(w);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry (valid + payload + control). An invalid entry always
// stores a zero control word so it reads as a NOP bubble.
module pipe_slot #(
    parameter int DATA_WIDTH = 96,
    parameter int CTRL_WIDTH = 9,
    parameter int CLEAR_DATA = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  drain,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [CTRL_WIDTH-1:0] ctrl
);

    // clr beats load; load beats drain so a slot can refill in the cycle it empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (load && !clr) begin
            valid <= 1'b1;
            data  <= in_data;
            ctrl  <= in_ctrl;
        end else if (clr || drain) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (CLEAR_DATA != 0) data <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with optional skid entry.
// Main slot drives the outputs; the skid slot catches one entry so o_READY can be registered.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 96,
    parameter int CTRL_WIDTH = CTRL_W,
    parameter int SKID_EN    = 1,
    parameter int CLEAR_DATA = 0
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_FLUSH,
    input  logic                  i_VALID,
    output logic                  o_READY,
    input  logic [DATA_WIDTH-1:0] i_DATA,
    input  logic [CTRL_WIDTH-1:0] i_CTRL,
    output logic                  o_VALID,
    input  logic                  i_READY,
    output logic [DATA_WIDTH-1:0] o_DATA,
    output logic [CTRL_WIDTH-1:0] o_CTRL,
    output logic [1:0]            o_OCC
);

    logic                  ready;
    logic                  accept;
    logic                  consume;
    logic                  main_valid;
    logic                  main_load;
    logic [DATA_WIDTH-1:0] main_data;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic [DATA_WIDTH-1:0] main_in_data;
    logic [CTRL_WIDTH-1:0] main_in_ctrl;
    logic                  skid_occ;

    assign accept  = i_VALID & ready;
    assign consume = main_valid & i_READY;

    generate
        if (SKID_EN != 0) begin : g_skid
            logic                  skid_valid;
            logic [DATA_WIDTH-1:0] skid_data;
            logic [CTRL_WIDTH-1:0] skid_ctrl;
            logic                  main_free;
            logic                  skid_load;
            logic                  skid_drain;

            // ready depends only on skid state, so no path from i_READY.
            assign ready        = ~skid_valid;
            assign main_free    = ~main_valid | consume;
            assign main_load    = main_free & (skid_valid | accept);
            assign main_in_data = skid_valid ? skid_data : i_DATA;
            assign main_in_ctrl = skid_valid ? skid_ctrl : i_CTRL;
            assign skid_load    = accept & ~main_free;
            assign skid_drain   = skid_valid & main_free;
            assign skid_occ     = skid_valid;

            pipe_slot #(
                .DATA_WIDTH (DATA_WIDTH),
                .CTRL_WIDTH (CTRL_WIDTH),
                .CLEAR_DATA (CLEAR_DATA)
            ) u_skid (
                .clk     (i_CLK),
                .rst     (i_RST),
                .clr     (i_FLUSH),
                .load    (skid_load),
                .drain   (skid_drain),
                .in_data (i_DATA),
                .in_ctrl (i_CTRL),
                .valid   (skid_valid),
                .data    (skid_data),
                .ctrl    (skid_ctrl)
            );
        end else begin : g_single
            assign ready        = ~main_valid | i_READY;
            assign main_load    = accept;
            assign main_in_data = i_DATA;
            assign main_in_ctrl = i_CTRL;
            assign skid_occ     = 1'b0;
        end
    endgenerate

    pipe_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk     (i_CLK),
        .rst     (i_RST),
        .clr     (i_FLUSH),
        .load    (main_load),
        .drain   (consume),
        .in_data (main_in_data),
        .in_ctrl (main_in_ctrl),
        .valid   (main_valid),
        .data    (main_data),
        .ctrl    (main_ctrl)
    );

    assign o_READY = ready;
    assign o_VALID = main_valid;
    assign o_CTRL  = main_valid ? main_ctrl : '0;
    assign o_DATA  = (CLEAR_DATA != 0 && !main_valid) ? '0 : main_data;
    assign o_OCC   = {1'b0, main_valid} + {1'b0, skid_occ};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench: skid/no-clear instance (a) and single/clear instance (b) against queue models.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 9;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_flush, a_vld, a_rdy_in, a_ovld, a_ordy;
    logic [DW-1:0] a_data, a_odata;
    logic [CW-1:0] a_ctrl, a_octrl;
    logic [1:0]    a_occ;
    logic          b_flush, b_vld, b_rdy_in, b_ovld, b_ordy;
    logic [DW-1:0] b_data, b_odata;
    logic [CW-1:0] b_ctrl, b_octrl;
    logic [1:0]    b_occ;

    pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID_EN(1), .CLEAR_DATA(0)) dut_a (
        .i_CLK(clk), .i_RST(rst), .i_FLUSH(a_flush), .i_VALID(a_vld), .o_READY(a_ordy),
        .i_DATA(a_data), .i_CTRL(a_ctrl), .o_VALID(a_ovld), .i_READY(a_rdy_in),
        .o_DATA(a_odata), .o_CTRL(a_octrl), .o_OCC(a_occ)
    );

    pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID_EN(0), .CLEAR_DATA(1)) dut_b (
        .i_CLK(clk), .i_RST(rst), .i_FLUSH(b_flush), .i_VALID(b_vld), .o_READY(b_ordy),
        .i_DATA(b_data), .i_CTRL(b_ctrl), .o_VALID(b_ovld), .i_READY(b_rdy_in),
        .o_DATA(b_odata), .o_CTRL(b_octrl), .o_OCC(b_occ)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a stage is a FIFO of capacity 2 (skid) or 1 (single).
    ent_t          qa[$];
    ent_t          qb[$];
    logic [DW-1:0] la;
    bit            acc_a, cons_a, acc_b, cons_b;

    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            la = '0;
        end else begin
            acc_a  = a_vld && (qa.size() < 2);
            cons_a = (qa.size() > 0) && a_rdy_in;
            if (a_flush) qa.delete();
            else begin
                if (cons_a) void'(qa.pop_front());
                if (acc_a) qa.push_back({a_data, a_ctrl});
            end
            if (qa.size() > 0) la = qa[0].d;

            acc_b  = b_vld && ((qb.size() == 0) || b_rdy_in);
            cons_b = (qb.size() > 0) && b_rdy_in;
            if (b_flush) qb.delete();
            else begin
                if (cons_b) void'(qb.pop_front());
                if (acc_b) qb.push_back({b_data, b_ctrl});
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_valid", a_ovld, qa.size() > 0);
            chk("a_ready", a_ordy, qa.size() < 2);
            chk("a_occ", a_occ, qa.size());
            chk("a_ctrl", a_octrl, (qa.size() > 0) ? qa[0].c : '0);
            chk("a_data", a_odata, (qa.size() > 0) ? qa[0].d : la);
            chk("b_valid", b_ovld, qb.size() > 0);
            chk("b_ready", b_ordy, (qb.size() == 0) || b_rdy_in);
            chk("b_occ", b_occ, qb.size());
            chk("b_occ_max", b_occ <= 2'd1, 1'b1);
            chk("b_ctrl", b_octrl, (qb.size() > 0) ? qb[0].c : '0);
            chk("b_data", b_odata, (qb.size() > 0) ? qb[0].d : '0);
        end
    end

    initial begin
        rst = 1'b1;
        a_flush = 0; a_vld = 1; a_rdy_in = 0; a_data = '1; a_ctrl = 9'h1FF;
        b_flush = 0; b_vld = 1; b_rdy_in = 0; b_data = '1; b_ctrl = 9'h1FF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", a_ovld, 0);
        chk("rst_ctrl", a_octrl, 0);
        chk("rst_data", a_odata, 0);
        chk("rst_occ", a_occ, 0);
        chk("rst_ready", a_ordy, 1);
        chk("rst_b_valid", b_ovld, 0);
        chk("rst_b_ctrl", b_octrl, 0);
        @(posedge clk); #1;
        rst = 0; a_vld = 0; b_vld = 0; a_rdy_in = 1; cmp_en = 1;

        // streaming 0..7, one per cycle, 1-cycle latency
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            a_vld = (k < 8); a_data = DW'(k); a_ctrl = CW'(k + 1);
            @(negedge clk);
            if (k > 0) begin
                chk("stream_valid", a_ovld, 1);
                chk("stream_data", a_odata, k - 1);
                chk("stream_ctrl", a_octrl, k);
            end
        end

        // backpressure: A into main, B into skid
        @(posedge clk); #1;
        a_rdy_in = 0; a_vld = 1; a_data = 96'hA; a_ctrl = 9'h0A;
        @(posedge clk); #1;
        a_data = 96'hB; a_ctrl = 9'h0B;
        @(posedge clk); #1;
        a_vld = 0;
        @(negedge clk);
        chk("bp_occ", a_occ, 2);
        chk("bp_ready", a_ordy, 0);
        chk("bp_data", a_odata, 96'hA);
        @(posedge clk); #1;
        a_rdy_in = 1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_b_data", a_odata, 96'hB);
        chk("bp_b_occ", a_occ, 1);
        chk("bp_ready_back", a_ordy, 1);

        // flush at occ=2 while C is offered
        @(posedge clk); #1;
        a_rdy_in = 0; a_vld = 1; a_data = 96'hD1; a_ctrl = 9'h1D1;
        @(posedge clk); #1;
        a_data = 96'hD2; a_ctrl = 9'h1D2;
        @(posedge clk); #1;
        a_data = 96'hC; a_ctrl = 9'h0C; a_flush = 1;
        @(negedge clk);
        chk("pre_flush_occ", a_occ, 2);
        @(posedge clk); #1;
        a_flush = 0; a_vld = 0; a_rdy_in = 1;
        @(negedge clk);
        chk("flush_valid", a_ovld, 0);
        chk("flush_ctrl", a_octrl, 0);
        chk("flush_occ", a_occ, 0);
        chk("flush_hold_data", a_odata, 96'hD1);
        repeat (3) begin
            @(negedge clk);
            chk("flush_no_c", a_ovld, 0);
        end

        // bubble with payload clearing
        @(posedge clk); #1;
        b_rdy_in = 0; b_vld = 1; b_data = 96'h5A5; b_ctrl = 9'h155;
        @(posedge clk); #1;
        b_vld = 0; b_flush = 1;
        @(negedge clk);
        chk("b_load_data", b_odata, 96'h5A5);
        @(posedge clk); #1;
        b_flush = 0;
        @(negedge clk);
        chk("b_flush_data", b_odata, 0);
        chk("b_flush_ctrl", b_octrl, 0);

        fork
            for (int i = 0; i < 300; i++) begin
                @(posedge clk); #1;
                a_vld    = ($urandom_range(0, 2) != 0);
                a_rdy_in = ($urandom_range(0, 1) != 0);
                a_data   = {$urandom, $urandom, $urandom};
                a_ctrl   = CW'($urandom_range(0, 511));
                a_flush  = ($urandom_range(0, 29) == 0);
            end
            for (int j = 0; j < 1000; j++) begin
                @(posedge clk); #1;
                b_vld    = ($urandom_range(0, 1) != 0);
                b_rdy_in = ($urandom_range(0, 1) != 0);
                b_data   = {$urandom, $urandom, $urandom};
                b_ctrl   = CW'($urandom_range(0, 511));
                b_flush  = ($urandom_range(0, 49) == 0);
            end
        join

        // reset mid-transfer
        @(posedge clk); #1;
        a_flush = 0; b_flush = 0; a_vld = 1; a_rdy_in = 0; b_vld = 1; b_rdy_in = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0; a_vld = 0; b_vld = 0;
        @(negedge clk);
        chk("midrst_a_occ", a_occ, 0);
        chk("midrst_b_occ", b_occ, 0);
        chk("midrst_a_ready", a_ordy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline-stage register that generalises the fixed decode/execute register into a reusable stage for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a packed data payload and a packed control word, supports valid/ready backpressure in place of a bare enable, and optionally adds a skid entry so the stage sustains full throughput with a registered `o_READY`. Flush inserts a bubble whose control word is forced to zero, so downstream stages treat it as a NOP.

## Interface
- `DATA_WIDTH`, 96: packed payload width (e.g. SrcA/SrcB/SignImm).
- `CTRL_WIDTH`, 9: packed control width (RegWrite, MemtoReg, MemWrite, ALUControl, ...); zero means NOP.
- `SKID_EN`, 1: 1 = two-entry skid with registered `o_READY`; 0 = single entry with combinational `o_READY`.
- `CLEAR_DATA`, 0: 1 = payload is also zeroed on flush and bubble; 0 = payload holds its last value.

- `i_CLK`  in  1  clock; all state updates on the rising edge.
- `i_RST`  in  1  reset, synchronous, active-high.
- `i_FLUSH`  in  1  synchronous clear; drops all held entries.
- `i_VALID`  in  1  upstream entry valid.
- `o_READY`  out  1  stage can accept.
- `i_DATA`  in  DATA_WIDTH  upstream payload.
- `i_CTRL`  in  CTRL_WIDTH  upstream control.
- `o_VALID`  out  1  output entry valid.
- `i_READY`  in  1  downstream accepts.
- `o_DATA`  out  DATA_WIDTH  output payload.
- `o_CTRL`  out  CTRL_WIDTH  output control; always zero when `o_VALID`=0.
- `o_OCC`  out  2  entries held (0..2; max 1 when SKID_EN=0).

## Operation
- Accept = `i_VALID & o_READY`. Consume = `o_VALID & i_READY`.
- Main entry drives the outputs. Skid entry exists only when SKID_EN=1.
- SKID_EN=1:
  - `o_READY` = ~skid_valid, registered.
  - The main entry loads when it is empty or consumed: from skid if skid_valid, else from input on accept.
  - Accept while main is full and not consumed: the input goes to skid.
  - Skid empties when it moves to main.
- SKID_EN=0: `o_READY` = ~o_VALID | i_READY. The main entry loads on accept.
- Bubble rule: whenever an entry is invalid, its stored control word is zero. `o_CTRL` is gated to zero when `o_VALID`=0, independent of storage. With CLEAR_DATA=1, `o_DATA` is zero when invalid.
- Flush: all valid bits clear and stored control clears. Payload clears only if CLEAR_DATA=1. The input presented in the flush cycle is discarded even if `i_VALID`=1. Downstream consume in that cycle is still honoured by the consumer (the entry was visible), but the stage drops it regardless.
- Priority: `i_RST` > `i_FLUSH` > handshake.
- Ordering is strict FIFO: skid data never overtakes main data.

## Timing
- Reset values (cycle after `i_RST` sampled high): `o_VALID`=0, `o_CTRL`=0, `o_DATA`=0, `o_OCC`=0, `o_READY`=1. Reset asserted mid-transfer discards all entries identically.
- Latency: 1 cycle from accept to `o_VALID`, when the stage is empty.
- Throughput: 1 entry per cycle with `i_READY` held high, for both modes.
- SKID_EN=1: `o_READY` falls the cycle after the skid fills, and rises the cycle after the skid drains. It has no combinational path from `i_READY`.
- Boundary cases:
  - Full (occ=2) with consume: skid moves to main and `o_READY` returns next cycle.
  - Empty with consume: cannot occur; `o_VALID`=0.
  - Simultaneous accept and consume at occ=1: occ stays 1 and main takes the input.
  - Flush with accept and consume: occ becomes 0.

## Structure
- Shared package `pipe_pkg`: control-field widths and offsets (REGWRITE, MEMTOREG[1:0], MEMWRITE, ALUCONTROL[2:0], ALUSRC, REGDST) and the `CTRL_NOP` = 0 constant. Stage wrappers pack and unpack through these.
- Sub-module `pipe_slot`: one entry holding valid, data and ctrl, with load/clear inputs and the bubble-zero rule. Instantiate it once for main and once for skid (under generate when SKID_EN=1).

## Test plan
- Reset: hold `i_RST`=1 for 2 cycles with `i_VALID`=1 and `i_CTRL`=9'h1FF -> `o_VALID`=0, `o_CTRL`=0, `o_OCC`=0, `o_READY`=1.
- Streaming: 8 entries with DATA=k and `i_READY`=1 -> outputs 0..7 in order, one per cycle, 1-cycle latency.
- Backpressure (SKID_EN=1): `i_READY`=0 while sending A and B -> `o_OCC`=2 and `o_READY`=0. Then `i_READY`=1 -> A then B out, and `o_READY`=1 the cycle after B moves to main.
- Flush at occ=2 with `i_VALID`=1 on C -> next cycle `o_VALID`=0, `o_CTRL`=0, `o_OCC`=0. C is never output.
- Bubble gating with CLEAR_DATA=0: after flush, `o_DATA` holds its last value and `o_CTRL`=0. With CLEAR_DATA=1, `o_DATA`=0.
- SKID_EN=0: randomised `i_VALID`/`i_READY` over 1000 cycles -> scoreboard matches, `o_OCC`≤1, and `o_READY`=~o_VALID|i_READY every cycle.
